hub75_scan_driver: RTL and testbench

//  Downstream consumer of the per-pixel pattern generator; drives a 64x64 HUB-75 panel at 1/32 scan.

---
 rtl/hub75_pkg.sv | 21 ++
 rtl/hub75_tag_delay.sv | 26 ++
 rtl/hub75_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and panel constants for the HUB-75 scan driver
package hub75_pkg;

  localparam int PANEL_WIDTH     = 64;
  localparam int PANEL_SCAN_ROWS = 32;

  typedef enum logic [2:0] {
    SHIFT,
    DRAIN,
    WAIT_ON,
    BLANK,
    LATCH
  } scan_state_t;

  typedef struct packed {
    logic valid;
    logic phase;
    logic last;
  } pix_tag_t;

endpackage

// File: rtl/hub75_tag_delay.sv
// rtl/hub75_tag_delay.sv - delay line aligning request tags with generator replies
module hub75_tag_delay
  import hub75_pkg::*;
#(
  parameter int PIPE_LATENCY = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  pix_tag_t tag_in,
  output pix_tag_t tag_out
);

  pix_tag_t stages [PIPE_LATENCY];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LATENCY; i++) stages[i] <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < PIPE_LATENCY; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[PIPE_LATENCY-1];

endmodule

// File: rtl/hub75_scan_driver.sv
// rtl/hub75_scan_driver.sv - 1/32-scan HUB-75 driver: pixel requests, row shifting, latch and OE timing
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int WIDTH        = PANEL_WIDTH,
  parameter int SCAN_ROWS    = PANEL_SCAN_ROWS,
  parameter int PIPE_LATENCY = 2,
  parameter int OE_CYCLES    = 256
) (
  input  logic       clock,
  input  logic       reset,
  output logic [5:0] pix_x,
  output logic [5:0] pix_y,
  output logic [9:0] pix_t,
  input  logic       pix_r,
  input  logic       pix_g,
  input  logic       pix_b,
  output logic       hub_r1,
  output logic       hub_g1,
  output logic       hub_b1,
  output logic       hub_r2,
  output logic       hub_g2,
  output logic       hub_b2,
  output logic       hub_clk,
  output logic       hub_lat,
  output logic       hub_oe_n,
  output logic [4:0] hub_addr,
  output logic       frame_start
);

  localparam logic [5:0]  LAST_COL = 6'(WIDTH - 1);
  localparam logic [4:0]  LAST_ROW = 5'(SCAN_ROWS - 1);
  localparam logic [5:0]  Y_OFFSET = 6'(SCAN_ROWS);
  localparam logic [15:0] OE_LOAD  = 16'(OE_CYCLES);

  scan_state_t state;
  logic [5:0]  col;
  logic        phase;
  logic [4:0]  row;
  logic [4:0]  row_inc;
  logic [15:0] on_timer;
  logic [15:0] on_timer_next;
  logic        dark_next;
  logic        last_seen;
  logic        clk_arm;
  logic        up_r, up_g, up_b;
  pix_tag_t    tag_in, tag_out;

  assign tag_in  = '{valid: (state == SHIFT), phase: phase, last: (phase && col == LAST_COL)};
  assign row_inc = (row == LAST_ROW) ? 5'd0 : row + 5'd1;

  hub75_tag_delay #(.PIPE_LATENCY(PIPE_LATENCY)) tag_delay (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // hub_oe_n is registered, so it is derived from the timer and state the next cycle will hold
  always_comb begin
    on_timer_next = (on_timer != 16'd0) ? on_timer - 16'd1 : 16'd0;
    if (state == LATCH) on_timer_next = OE_LOAD;
  end

  assign dark_next = (state == BLANK) || (state == WAIT_ON && on_timer <= 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SHIFT;
      col         <= 6'd0;
      phase       <= 1'b0;
      row         <= 5'd0;
      on_timer    <= 16'd0;
      last_seen   <= 1'b0;
      pix_x       <= 6'd0;
      pix_y       <= 6'd0;
      pix_t       <= 10'd0;
      hub_lat     <= 1'b0;
      hub_oe_n    <= 1'b1;
      hub_addr    <= 5'd0;
      frame_start <= 1'b0;
    end else begin
      on_timer    <= on_timer_next;
      hub_oe_n    <= (on_timer_next == 16'd0) || dark_next;
      hub_lat     <= 1'b0;
      frame_start <= 1'b0;
      if (tag_out.valid && tag_out.last) last_seen <= 1'b1;
      case (state)
        SHIFT: begin
          if (!phase) begin
            phase <= 1'b1;
            pix_y <= {1'b0, row} + Y_OFFSET;
          end else if (col == LAST_COL) begin
            state <= DRAIN;
          end else begin
            phase <= 1'b0;
            col   <= col + 6'd1;
            pix_x <= col + 6'd1;
            pix_y <= {1'b0, row};
          end
        end
        DRAIN: begin
          // last pair's data is on the pins; its hub_clk high cycle follows in WAIT_ON
          if (last_seen) begin
            state     <= WAIT_ON;
            last_seen <= 1'b0;
          end
        end
        WAIT_ON: begin
          if (on_timer <= 16'd1) state <= BLANK;
        end
        BLANK: begin
          state    <= LATCH;
          hub_lat  <= 1'b1;
          hub_addr <= row;
          if (row == LAST_ROW) begin
            pix_t       <= pix_t + 10'd1;
            frame_start <= 1'b1;
          end
        end
        LATCH: begin
          state <= SHIFT;
          row   <= row_inc;
          col   <= 6'd0;
          phase <= 1'b0;
          pix_x <= 6'd0;
          pix_y <= {1'b0, row_inc};
        end
        default: state <= SHIFT;
      endcase
    end
  end

  // Upper-half reply is staged until its lower-half partner arrives one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      up_r    <= 1'b0;
      up_g    <= 1'b0;
      up_b    <= 1'b0;
      hub_r1  <= 1'b0;
      hub_g1  <= 1'b0;
      hub_b1  <= 1'b0;
      hub_r2  <= 1'b0;
      hub_g2  <= 1'b0;
      hub_b2  <= 1'b0;
      hub_clk <= 1'b0;
      clk_arm <= 1'b0;
    end else begin
      hub_clk <= clk_arm;
      clk_arm <= tag_out.valid && tag_out.phase;
      if (tag_out.valid && !tag_out.phase) begin
        up_r <= pix_r;
        up_g <= pix_g;
        up_b <= pix_b;
      end
      if (tag_out.valid && tag_out.phase) begin
        hub_r1 <= up_r;
        hub_g1 <= up_g;
        hub_b1 <= up_b;
        hub_r2 <= pix_r;
        hub_g2 <= pix_g;
        hub_b2 <= pix_b;
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb/tb_hub75_scan_driver.sv - directed self-checking bench for hub75_scan_driver
module tb_hub75_scan_driver;

  localparam int ROW_P = 134;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Instance a: full panel, short on-time
  logic [5:0] a_pix_x, a_pix_y;
  logic [9:0] a_pix_t;
  logic       a_pix_r, a_pix_g, a_pix_b;
  logic       a_r1, a_g1, a_b1, a_r2, a_g2, a_b2;
  logic       a_clk, a_lat, a_oe_n, a_fs;
  logic [4:0] a_addr;

  hub75_scan_driver #(.OE_CYCLES(16)) dut_a (
    .clock(clock), .reset(reset),
    .pix_x(a_pix_x), .pix_y(a_pix_y), .pix_t(a_pix_t),
    .pix_r(a_pix_r), .pix_g(a_pix_g), .pix_b(a_pix_b),
    .hub_r1(a_r1), .hub_g1(a_g1), .hub_b1(a_b1),
    .hub_r2(a_r2), .hub_g2(a_g2), .hub_b2(a_b2),
    .hub_clk(a_clk), .hub_lat(a_lat), .hub_oe_n(a_oe_n),
    .hub_addr(a_addr), .frame_start(a_fs)
  );

  // Generator model, latency 2: r=x[0], g=(y>=32), b=1
  logic [2:0] gen_d1, gen_d2;
  always @(posedge clock) begin
    gen_d1 <= {a_pix_x[0], (a_pix_y >= 6'd32), 1'b1};
    gen_d2 <= gen_d1;
  end
  assign {a_pix_r, a_pix_g, a_pix_b} = gen_d2;

  // Instance b: long on-time
  logic [5:0] b_pix_x, b_pix_y;
  logic [9:0] b_pix_t;
  logic       b_r1, b_g1, b_b1, b_r2, b_g2, b_b2;
  logic       b_clk, b_lat, b_oe_n, b_fs;
  logic [4:0] b_addr;

  hub75_scan_driver #(.OE_CYCLES(300)) dut_b (
    .clock(clock), .reset(reset),
    .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_t(b_pix_t),
    .pix_r(1'b0), .pix_g(1'b0), .pix_b(1'b0),
    .hub_r1(b_r1), .hub_g1(b_g1), .hub_b1(b_b1),
    .hub_r2(b_r2), .hub_g2(b_g2), .hub_b2(b_b2),
    .hub_clk(b_clk), .hub_lat(b_lat), .hub_oe_n(b_oe_n),
    .hub_addr(b_addr), .frame_start(b_fs)
  );

  // Instance c: tiny panel so 1024 frames fit in a short run (frame = 2 rows x 8 cycles)
  logic [5:0] c_pix_x, c_pix_y;
  logic [9:0] c_pix_t;
  logic       c_r1, c_g1, c_b1, c_r2, c_g2, c_b2;
  logic       c_clk, c_lat, c_oe_n, c_fs;
  logic [4:0] c_addr;

  hub75_scan_driver #(.WIDTH(1), .SCAN_ROWS(2), .OE_CYCLES(4)) dut_c (
    .clock(clock), .reset(reset),
    .pix_x(c_pix_x), .pix_y(c_pix_y), .pix_t(c_pix_t),
    .pix_r(1'b0), .pix_g(1'b0), .pix_b(1'b0),
    .hub_r1(c_r1), .hub_g1(c_g1), .hub_b1(c_b1),
    .hub_r2(c_r2), .hub_g2(c_g2), .hub_b2(c_b2),
    .hub_clk(c_clk), .hub_lat(c_lat), .hub_oe_n(c_oe_n),
    .hub_addr(c_addr), .frame_start(c_fs)
  );

  // Monitor b: first three latch times and first oe_n low run
  int b_n = 0, b_lats = 0, b_run = 0, b_first_run = 0;
  int b_lat_at [3];
  always @(negedge clock) begin
    if (reset) begin
      b_n   = 0;
      b_run = 0;
    end else begin
      if (b_lat && b_lats < 3) begin
        b_lat_at[b_lats] = b_n;
        b_lats++;
      end
      if (!b_oe_n) b_run++;
      else begin
        if (b_run > 0 && b_first_run == 0) b_first_run = b_run;
        b_run = 0;
      end
      b_n++;
    end
  end

  // Monitor c: pix_t seen at frame pulses 1023 and 1024
  int c_frames = 0;
  logic [9:0] c_t_1023 = 10'h3aa, c_t_1024 = 10'h3aa;
  always @(negedge clock) begin
    if (reset) c_frames = 0;
    else if (c_fs) begin
      c_frames++;
      if (c_frames == 1023) c_t_1023 = c_pix_t;
      if (c_frames == 1024) c_t_1024 = c_pix_t;
    end
  end

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_oe_n"}, 32'(a_oe_n), 32'd1);
    check_eq({tag, "_lat"}, 32'(a_lat), 32'd0);
    check_eq({tag, "_clk"}, 32'(a_clk), 32'd0);
    check_eq({tag, "_addr"}, 32'(a_addr), 32'd0);
    check_eq({tag, "_pix_x"}, 32'(a_pix_x), 32'd0);
    check_eq({tag, "_pix_y"}, 32'(a_pix_y), 32'd0);
    check_eq({tag, "_pix_t"}, 32'(a_pix_t), 32'd0);
    check_eq({tag, "_fs"}, 32'(a_fs), 32'd0);
    check_eq({tag, "_data"}, 32'({a_r1, a_g1, a_b1, a_r2, a_g2, a_b2}), 32'd0);
  endtask

  // Walks cycle n = 0.. after reset release and checks every pin of instance a
  task automatic check_run(input int ncycles);
    for (int n = 0; n < ncycles; n++) begin
      int m, r, k;
      int exp_clk, exp_lat, exp_oe_n, exp_addr, exp_fs, exp_t, exp_x, exp_y;
      m = n % ROW_P;
      r = (n / ROW_P) % 32;
      exp_clk  = (m >= 5 && m <= 131 && (m % 2) == 1) ? 1 : 0;
      exp_lat  = (m == 133) ? 1 : 0;
      exp_oe_n = (n >= ROW_P && m < 16) ? 0 : 1;
      exp_addr = (n < 133) ? 0 : ((n - 133) / ROW_P) % 32;
      exp_fs   = (m == 133 && r == 31) ? 1 : 0;
      exp_t    = (n >= ROW_P * 31 + 133) ? 1 : 0;
      exp_x    = (m < 128) ? m / 2 : 63;
      exp_y    = r + (((m < 128) ? (m % 2) : 1) * 32);
      check_eq("hub_clk", 32'(a_clk), 32'(exp_clk));
      check_eq("hub_lat", 32'(a_lat), 32'(exp_lat));
      check_eq("hub_oe_n", 32'(a_oe_n), 32'(exp_oe_n));
      check_eq("hub_addr", 32'(a_addr), 32'(exp_addr));
      check_eq("frame_start", 32'(a_fs), 32'(exp_fs));
      check_eq("pix_t", 32'(a_pix_t), 32'(exp_t));
      check_eq("pix_x", 32'(a_pix_x), 32'(exp_x));
      check_eq("pix_y", 32'(a_pix_y), 32'(exp_y));
      if (exp_clk == 1) begin
        k = (m - 5) / 2;
        check_eq("rise_data", 32'({a_r1, a_g1, a_b1, a_r2, a_g2, a_b2}),
                 32'({k[0], 1'b0, 1'b1, k[0], 1'b1, 1'b1}));
      end
      @(negedge clock);
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    check_run(ROW_P * 33);

    check_eq("b_first_lat", 32'(b_lat_at[0]), 32'd133);
    check_eq("b_row_period_1", 32'(b_lat_at[1] - b_lat_at[0]), 32'd302);
    check_eq("b_row_period_2", 32'(b_lat_at[2] - b_lat_at[1]), 32'd302);
    check_eq("b_oe_low_run", 32'(b_first_run), 32'd300);

    // Abort mid-row while hub_clk is high at column 20
    guard = 0;
    while (!(a_pix_x == 6'd20 && a_clk == 1'b1) && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    check_eq("find_col20", 32'(guard < 300), 32'd1);
    #1 reset = 1'b1;
    #1 check_reset_values("async_reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_run(150);

    guard = 0;
    while (c_frames < 1024 && guard < 20000) begin
      @(negedge clock);
      guard++;
    end
    check_eq("c_frames_reached", 32'(c_frames >= 1024), 32'd1);
    check_eq("c_pix_t_1023", 32'(c_t_1023), 32'd1023);
    check_eq("c_pix_t_wrap", 32'(c_t_1024), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
